// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the Memoria arbiter
//                (FSM state encoding, access owner encoding).
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  // Read wait counter width; covers RD_LAT 1..3 (counter holds RD_LAT-1).
  localparam int c_wait_w = 2;

endpackage
`default_nettype wire

// File: rtl/mem_arb_fair.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_fair
//  Description : Winner selection between CPU and debug port. The CPU has
//                priority, but after MAX_CPU_BURST consecutive CPU grants
//                taken while the debug port waits, the debug port wins.
//  Revision    : 1.0  initial release
//  Ports       :
//    Clk       in   clock
//    Reset     in   synchronous active-high reset
//    cpu_req   in   CPU request
//    dbg_req   in   debug request
//    in_idle   in   arbiter FSM is in IDLE this cycle
//    cpu_grant in   CPU grant strobe
//    dbg_grant in   debug grant strobe
//    winner    out  port that wins if arbitration happens this cycle
// ============================================================================
module mem_arb_fair
  import mem_arb_pkg::*;
#(
  parameter int MAX_CPU_BURST = 4
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  logic   in_idle,
  input  logic   cpu_grant,
  input  logic   dbg_grant,
  output owner_t winner
);

  localparam int c_cnt_w = $clog2(MAX_CPU_BURST + 1);
  localparam logic [c_cnt_w-1:0] c_max_run = c_cnt_w'(MAX_CPU_BURST);

  logic [c_cnt_w-1:0] r_cpu_run_cnt;

  // Counts CPU grants that overtook a waiting debug request. Any idle cycle
  // without a debug request ends the "starvation window".
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cpu_run_cnt <= '0;
    end else if (dbg_grant || (in_idle && !dbg_req)) begin
      r_cpu_run_cnt <= '0;
    end else if (cpu_grant && dbg_req && (r_cpu_run_cnt != c_max_run)) begin
      r_cpu_run_cnt <= r_cpu_run_cnt + c_cnt_w'(1);
    end
  end

  always_comb begin
    winner = OWN_CPU;
    if (dbg_req && (!cpu_req || (r_cpu_run_cnt == c_max_run))) begin
      winner = OWN_DBG;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares single-port Memoria between the CPU datapath and a
//                debug/loader port. One outstanding access at a time; read
//                data is steered into the owning port's rdata register.
//  Revision    : 1.0  initial release
//  Ports       :
//    Clk, Reset                          clock, synchronous active-high reset
//    cpu_req/wr/addr/wdata               CPU access request
//    cpu_gnt/rvalid/rdata/stall          CPU grant, read response, stall
//    dbg_req/wr/addr/wdata               debug access request
//    dbg_gnt/rvalid/rdata                debug grant, read response
//    mem_addr/mem_wr/mem_wdata           to Memoria
//    mem_rdata                           from Memoria (RD_LAT cycles latency)
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int RD_LAT        = 1,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t          r_state;
  owner_t              r_owner;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dbg_rdata;
  logic                r_cpu_gnt;
  logic                r_dbg_gnt;
  logic                r_cpu_rvalid;
  logic                r_dbg_rvalid;

  owner_t              w_winner;
  logic                w_own_wr;
  logic [ADDR_W-1:0]   w_own_addr;
  logic [DATA_W-1:0]   w_own_wdata;
  logic                w_addr_phase;

  mem_arb_fair #(
    .MAX_CPU_BURST(MAX_CPU_BURST)
  ) u_fair (
    .Clk      (Clk),
    .Reset    (Reset),
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .in_idle  (r_state == IDLE),
    .cpu_grant(r_cpu_gnt),
    .dbg_grant(r_dbg_gnt),
    .winner   (w_winner)
  );

  // Owner-side request fields; requesters hold them stable until completion.
  assign w_own_wr     = (r_owner == OWN_DBG) ? dbg_wr    : cpu_wr;
  assign w_own_addr   = (r_owner == OWN_DBG) ? dbg_addr  : cpu_addr;
  assign w_own_wdata  = (r_owner == OWN_DBG) ? dbg_wdata : cpu_wdata;
  assign w_addr_phase = (r_state == ISSUE) || (r_state == RD_WAIT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_CPU;
      r_wait_cnt   <= '0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
      r_cpu_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_cpu_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            r_owner   <= w_winner;
            r_state   <= ISSUE;
            r_cpu_gnt <= (w_winner == OWN_CPU);
            r_dbg_gnt <= (w_winner == OWN_DBG);
          end
        end
        ISSUE: begin
          if (w_own_wr) begin
            r_state <= IDLE;
          end else begin
            r_state    <= RD_WAIT;
            r_wait_cnt <= c_wait_w'(RD_LAT - 1);
          end
        end
        RD_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state <= RESP;
            if (r_owner == OWN_DBG) begin
              r_dbg_rdata  <= mem_rdata;
              r_dbg_rvalid <= 1'b1;
            end else begin
              r_cpu_rdata  <= mem_rdata;
              r_cpu_rvalid <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - c_wait_w'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are masked during Reset so that a grant is never shown for an
  // access that the reset is about to abort.
  assign cpu_gnt    = r_cpu_gnt    & ~Reset;
  assign dbg_gnt    = r_dbg_gnt    & ~Reset;
  assign cpu_rvalid = r_cpu_rvalid & ~Reset;
  assign dbg_rvalid = r_dbg_rvalid & ~Reset;
  assign cpu_rdata  = r_cpu_rdata;
  assign dbg_rdata  = r_dbg_rdata;

  assign mem_addr  = w_addr_phase ? w_own_addr : '0;
  assign mem_wdata = w_addr_phase ? w_own_wdata : '0;
  assign mem_wr    = (r_state == ISSUE) & w_own_wr & ~Reset;

  // A CPU access completes on its write grant or on its read response.
  assign cpu_stall = cpu_req & ~((cpu_gnt & cpu_wr) | cpu_rvalid);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench. Two arbiters (RD_LAT=1 and RD_LAT=3),
//                each with its own Memoria model. Expected timing and data
//                are derived from transaction-level rules and a shadow memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        cpu_req    [2];
  logic        cpu_wr     [2];
  logic [31:0] cpu_addr   [2];
  logic [31:0] cpu_wdata  [2];
  logic        cpu_gnt    [2];
  logic        cpu_rvalid [2];
  logic [31:0] cpu_rdata  [2];
  logic        cpu_stall  [2];
  logic        dbg_req    [2];
  logic        dbg_wr     [2];
  logic [31:0] dbg_addr   [2];
  logic [31:0] dbg_wdata  [2];
  logic        dbg_gnt    [2];
  logic        dbg_rvalid [2];
  logic [31:0] dbg_rdata  [2];
  logic [31:0] mem_addr   [2];
  logic        mem_wr     [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];

  logic        load;
  logic [31:0] mem     [2][64];
  logic [31:0] pipe    [2][3];
  logic [31:0] ref_mem [2][64];
  logic [31:0] exp_rd  [2][2];

  int vectors     = 0;
  int miscompares = 0;

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1), .MAX_CPU_BURST(4)) u_dut_l1 (
    .Clk(clk), .Reset(rst[0]),
    .cpu_req(cpu_req[0]), .cpu_wr(cpu_wr[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_gnt(cpu_gnt[0]), .cpu_rvalid(cpu_rvalid[0]), .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
    .dbg_req(dbg_req[0]), .dbg_wr(dbg_wr[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
    .dbg_gnt(dbg_gnt[0]), .dbg_rvalid(dbg_rvalid[0]), .dbg_rdata(dbg_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3), .MAX_CPU_BURST(4)) u_dut_l3 (
    .Clk(clk), .Reset(rst[1]),
    .cpu_req(cpu_req[1]), .cpu_wr(cpu_wr[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_gnt(cpu_gnt[1]), .cpu_rvalid(cpu_rvalid[1]), .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
    .dbg_req(dbg_req[1]), .dbg_wr(dbg_wr[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
    .dbg_gnt(dbg_gnt[1]), .dbg_rvalid(dbg_rvalid[1]), .dbg_rdata(dbg_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic logic [31:0] seed(input int i);
    logic [31:0] v;
    v = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    if (i == 4) v = 32'hDEAD_BEEF;
    return v;
  endfunction

  // Memoria model: synchronous write, read data delayed through a pipeline.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (load) begin
        for (int i = 0; i < 64; i++) mem[d][i] <= seed(i);
      end else if (mem_wr[d]) begin
        mem[d][mem_addr[d][7:2]] <= mem_wdata[d];
      end
      pipe[d][0] <= mem[d][mem_addr[d][7:2]];
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  task automatic chk1(input int d, input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL d%0d %s: observed %b expected %b", d, tag, obs, exp);
    end
  endtask

  task automatic chk32(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL d%0d %s: observed 0x%08h expected 0x%08h", d, tag, obs, exp);
    end
  endtask

  // One isolated transaction (CPU, DBG or both issued together from IDLE).
  // Called and returning at 1 time unit after a rising edge.
  task automatic run_txn(input int d,
                         input bit ce, input bit cw, input logic [31:0] ca, input logic [31:0] cwd,
                         input bit de, input bit dw, input logic [31:0] da, input logic [31:0] dwd);
    int L, cg, cdone, dg, ddone, last;
    logic [31:0] cexp, dexp;
    L = (d == 0) ? 1 : 3;
    cg = -1; cdone = -1; dg = -1; ddone = -1; cexp = '0; dexp = '0;
    // Grant order: CPU first when both ask from an idle, unstarved arbiter.
    if (ce) begin
      cg    = 1;
      cdone = cw ? 1 : 2 + L;
      if (cw) ref_mem[d][ca[7:2]] = cwd; else cexp = ref_mem[d][ca[7:2]];
    end
    if (de) begin
      dg    = ce ? cdone + 2 : 1;
      ddone = dw ? dg : dg + 1 + L;
      if (dw) ref_mem[d][da[7:2]] = dwd; else dexp = ref_mem[d][da[7:2]];
    end
    last = ((cdone > ddone) ? cdone : ddone) + 1;
    if (ce) begin cpu_wr[d] = cw; cpu_addr[d] = ca; cpu_wdata[d] = cwd; end
    if (de) begin dbg_wr[d] = dw; dbg_addr[d] = da; dbg_wdata[d] = dwd; end
    for (int t = 0; t <= last; t++) begin
      cpu_req[d] = ce && (t <= cdone);
      dbg_req[d] = de && (t <= ddone);
      @(negedge clk);
      if (ce && !cw && t == cdone) exp_rd[d][0] = cexp;
      if (de && !dw && t == ddone) exp_rd[d][1] = dexp;
      chk1(d, "cpu_gnt", cpu_gnt[d], ce && t == cg);
      chk1(d, "dbg_gnt", dbg_gnt[d], de && t == dg);
      chk1(d, "cpu_rvalid", cpu_rvalid[d], ce && !cw && t == cdone);
      chk1(d, "dbg_rvalid", dbg_rvalid[d], de && !dw && t == ddone);
      chk1(d, "cpu_stall", cpu_stall[d], ce && (t < cdone));
      chk1(d, "mem_wr", mem_wr[d], (ce && cw && t == cg) || (de && dw && t == dg));
      chk32(d, "cpu_rdata", cpu_rdata[d], exp_rd[d][0]);
      chk32(d, "dbg_rdata", dbg_rdata[d], exp_rd[d][1]);
      if (ce && t == cg) chk32(d, "cpu_mem_addr", mem_addr[d], ca);
      if (de && t == dg) chk32(d, "dbg_mem_addr", mem_addr[d], da);
      if (ce && cw && t == cg) chk32(d, "cpu_mem_wdata", mem_wdata[d], cwd);
      if (de && dw && t == dg) chk32(d, "dbg_mem_wdata", mem_wdata[d], dwd);
      if (t == 0 || t == last) chk32(d, "idle_mem_addr", mem_addr[d], 32'h0);
      @(posedge clk); #1;
    end
  endtask

  // CPU streams six reads with dbg_req held: expect 4 CPU, 1 DBG, then CPU.
  task automatic run_burst(input int d);
    int cdone, ddone, seq[$];
    int exp_seq[7];
    bit dact;
    exp_seq = '{0, 0, 0, 0, 1, 0, 0};
    cdone = 0; ddone = 0; dact = 1'b0;
    cpu_req[d] = 1'b1; cpu_wr[d] = 1'b0; cpu_addr[d] = 32'h80;
    dbg_req[d] = 1'b1; dbg_wr[d] = 1'b0; dbg_addr[d] = 32'hC0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cpu_gnt[d]) seq.push_back(0);
      if (dbg_gnt[d]) begin seq.push_back(1); dact = 1'b1; end
      if (dact) chk1(d, "burst_cpu_stall", cpu_stall[d], 1'b1);
      if (cpu_rvalid[d]) begin exp_rd[d][0] = ref_mem[d][32 + cdone]; cdone++; end
      if (dbg_rvalid[d]) begin exp_rd[d][1] = ref_mem[d][48]; ddone++; dact = 1'b0; end
      chk32(d, "burst_cpu_rdata", cpu_rdata[d], exp_rd[d][0]);
      chk32(d, "burst_dbg_rdata", dbg_rdata[d], exp_rd[d][1]);
      @(posedge clk); #1;
      cpu_req[d]  = (cdone < 6);
      cpu_addr[d] = 32'h80 + 32'(cdone * 4);
      dbg_req[d]  = (ddone < 1);
      if (cdone == 6 && ddone == 1) break;
    end
    chk32(d, "burst_cpu_done", 32'(cdone), 32'd6);
    chk32(d, "burst_dbg_done", 32'(ddone), 32'd1);
    chk32(d, "burst_grant_count", 32'(seq.size()), 32'd7);
    for (int k = 0; k < 7 && k < seq.size(); k++)
      chk32(d, $sformatf("burst_grant_order[%0d]", k), 32'(seq[k]), 32'(exp_seq[k]));
  endtask

  // Reset lands on the RD_WAIT cycle of a debug read.
  task automatic run_reset(input int d);
    dbg_req[d] = 1'b1; dbg_wr[d] = 1'b0; dbg_addr[d] = 32'h30;
    @(negedge clk);
    chk1(d, "rst_dbg_gnt_c0", dbg_gnt[d], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1(d, "rst_dbg_gnt_c1", dbg_gnt[d], 1'b1);
    @(posedge clk); #1;
    rst[d] = 1'b1; dbg_req[d] = 1'b0;
    @(negedge clk);
    chk1(d, "rst_dbg_rvalid", dbg_rvalid[d], 1'b0);
    chk1(d, "rst_dbg_gnt", dbg_gnt[d], 1'b0);
    chk1(d, "rst_mem_wr", mem_wr[d], 1'b0);
    @(posedge clk); #1;
    rst[d] = 1'b0;
    exp_rd[d][0] = '0; exp_rd[d][1] = '0;
    // Immediate CPU read: grant one cycle later shows the FSM is idle, and the
    // per-cycle checks cover the window where the aborted rvalid would appear.
    run_txn(d, 1'b1, 1'b0, 32'h34, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    load = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      cpu_req[d] = 1'b0; cpu_wr[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      dbg_req[d] = 1'b0; dbg_wr[d] = 1'b0; dbg_addr[d] = '0; dbg_wdata[d] = '0;
      exp_rd[d][0] = '0; exp_rd[d][1] = '0;
      for (int i = 0; i < 64; i++) ref_mem[d][i] = seed(i);
    end

    // Reset held three cycles with random requests.
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 2; d++) begin
        cpu_req[d] = 1'($urandom); cpu_wr[d] = 1'($urandom);
        cpu_addr[d] = $urandom; cpu_wdata[d] = $urandom;
        dbg_req[d] = 1'($urandom); dbg_wr[d] = 1'($urandom);
        dbg_addr[d] = $urandom; dbg_wdata[d] = $urandom;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk1(d, "reset_cpu_gnt", cpu_gnt[d], 1'b0);
        chk1(d, "reset_dbg_gnt", dbg_gnt[d], 1'b0);
        chk1(d, "reset_cpu_rvalid", cpu_rvalid[d], 1'b0);
        chk1(d, "reset_dbg_rvalid", dbg_rvalid[d], 1'b0);
        chk1(d, "reset_mem_wr", mem_wr[d], 1'b0);
        chk32(d, "reset_mem_addr", mem_addr[d], 32'h0);
        chk32(d, "reset_cpu_rdata", cpu_rdata[d], 32'h0);
        chk32(d, "reset_dbg_rdata", dbg_rdata[d], 32'h0);
      end
      @(posedge clk); #1;
      load = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; cpu_req[d] = 1'b0; dbg_req[d] = 1'b0;
    end

    // CPU read of 0x10 with RD_LAT=1.
    run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk32(0, "cpu_read_0x10", cpu_rdata[0], 32'hDEAD_BEEF);

    // Same-cycle writes, then read both back.
    for (int d = 0; d < 2; d++) begin
      run_txn(d, 1'b1, 1'b1, 32'h20, 32'h1, 1'b1, 1'b1, 32'h24, 32'h2);
      run_txn(d, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk32(d, "readback_0x20", cpu_rdata[d], 32'h1);
      run_txn(d, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
      chk32(d, "readback_0x24", dbg_rdata[d], 32'h2);
    end

    for (int d = 0; d < 2; d++) run_burst(d);
    for (int d = 0; d < 2; d++) run_reset(d);

    // RD_LAT=3: alternating CPU/DBG reads, then simultaneous reads.
    for (int k = 0; k < 3; k++) begin
      run_txn(1, 1'b1, 1'b0, 32'(k * 8), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      run_txn(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'(k * 8 + 4), 32'h0);
      run_txn(1, 1'b1, 1'b0, 32'(k * 8 + 64), 32'h0, 1'b1, 1'b0, 32'(k * 8 + 68), 32'h0);
    end

    // Randomized isolated transactions on both latencies.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 24; n++) begin
        int mode;
        mode = $urandom_range(1, 3);
        run_txn(d, mode[0], 1'($urandom), 32'($urandom_range(0, 63)) << 2, $urandom,
                   mode[1], 1'($urandom), 32'($urandom_range(0, 63)) << 2, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
